// File: rtl/nrisc_ula_wb_pkg.sv
// Shared constants and types for the ULA writeback stage: default widths,
// flag bit positions and the skid-buffer occupancy encoding.
package nrisc_ula_wb_pkg;

  localparam int DEF_TAM   = 16;
  localparam int DEF_RADDR = 4;
  localparam int DEF_CNT_W = 16;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_MINUS = 2;
  localparam int FLAG_W     = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/nrisc_skid2.sv
// Two-entry in-order skid buffer. HEAD is the oldest entry; SKID only fills
// when HEAD cannot drain. Ready depends on registered occupancy alone.
module nrisc_skid2
  import nrisc_ula_wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data
);

  occ_e         state_reg;
  logic [W-1:0] head_reg;
  logic [W-1:0] skid_reg;
  logic         accept;

  assign in_ready   = (state_reg != OCC_TWO);
  assign head_valid = (state_reg != OCC_EMPTY);
  assign head_data  = head_reg;
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= OCC_EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else if (flush) begin
      // Flush drops both entries and any op offered this cycle.
      state_reg <= OCC_EMPTY;
    end else begin
      case (state_reg)
        OCC_EMPTY: begin
          if (accept) begin
            head_reg  <= in_data;
            state_reg <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            head_reg <= in_data;
          end else if (accept) begin
            skid_reg  <= in_data;
            state_reg <= OCC_TWO;
          end else if (pop) begin
            state_reg <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head_reg  <= skid_reg;
            state_reg <= OCC_ONE;
          end
        end
        default: state_reg <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/nrisc_ula_wb.sv
// ULA writeback stage: buffers ULA results, retires them into the register
// file and flag register, and exposes the head entry for operand forwarding.
module nrisc_ula_wb
  import nrisc_ula_wb_pkg::*;
#(
  parameter int TAM   = DEF_TAM,
  parameter int RADDR = DEF_RADDR,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAM-1:0]    in_result,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic [RADDR-1:0]  in_rd,
  input  logic              in_we_reg,
  input  logic              in_we_flags,
  input  logic              flush,
  input  logic              wb_stall,
  output logic              rf_wr_en,
  output logic [RADDR-1:0]  rf_wr_addr,
  output logic [TAM-1:0]    rf_wr_data,
  output logic [FLAG_W-1:0] flags_q,
  output logic              fwd_valid,
  output logic [RADDR-1:0]  fwd_addr,
  output logic [TAM-1:0]    fwd_data,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int PW = TAM + FLAG_W + RADDR + 2;

  logic [PW-1:0]     in_pay;
  logic [PW-1:0]     head_pay;
  logic              head_valid;
  logic [TAM-1:0]    head_result;
  logic [FLAG_W-1:0] head_flags;
  logic [RADDR-1:0]  head_rd;
  logic              head_we_reg;
  logic              head_we_flags;
  logic              head_writes_rf;
  logic              retire;

  logic [FLAG_W-1:0] flags_reg;
  logic [CNT_W-1:0]  cnt_reg;

  assign in_pay = {in_result, in_flags, in_rd, in_we_reg, in_we_flags};
  assign {head_result, head_flags, head_rd, head_we_reg, head_we_flags} = head_pay;

  nrisc_skid2 #(
    .W(PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .pop       (retire),
    .head_valid(head_valid),
    .head_data (head_pay)
  );

  // A flush in the same cycle cancels the retire, so nothing reaches RF or flags.
  assign retire         = head_valid & ~wb_stall & ~flush;
  assign head_writes_rf = head_valid & head_we_reg & (head_rd != '0);

  assign rf_wr_en   = head_writes_rf & retire;
  assign rf_wr_addr = head_valid ? head_rd : '0;
  assign rf_wr_data = head_valid ? head_result : '0;

  assign fwd_valid = head_writes_rf;
  assign fwd_addr  = rf_wr_addr;
  assign fwd_data  = rf_wr_data;

  assign flags_q     = flags_reg;
  assign retired_cnt = cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_reg <= '0;
      cnt_reg   <= '0;
    end else if (retire) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (head_we_flags) begin
        flags_reg <= head_flags;
      end
    end
  end

endmodule

// File: tb/tb_nrisc_ula_wb.sv
// Directed bench for the ULA writeback stage: a per-cycle vector table plus
// hand-written flush, reset and counter-wrap sequences.
module tb_nrisc_ula_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [2:0]  in_flags;
  logic [3:0]  in_rd;
  logic        in_we_reg;
  logic        in_we_flags;
  logic        flush;
  logic        wb_stall;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [2:0]  flags_q;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic [15:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nrisc_ula_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_rd      (in_rd),
    .in_we_reg  (in_we_reg),
    .in_we_flags(in_we_flags),
    .flush      (flush),
    .wb_stall   (wb_stall),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .flags_q    (flags_q),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .retired_cnt(retired_cnt)
  );

  // ctl = {in_valid, we_reg, we_flags, wb_stall}; ew = {exp in_ready, exp rf_wr_en}
  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  fl;
    logic [3:0]  rd;
    logic [3:0]  ctl;
    logic [1:0]  ew;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic        e_fv;
    logic [2:0]  e_flags;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [15:0] res, input logic [2:0] fl,
                              input logic [3:0] rd, input logic [3:0] ctl,
                              input logic [1:0] ew, input logic [3:0] e_addr,
                              input logic [15:0] e_data, input logic e_fv,
                              input logic [2:0] e_flags, input logic [15:0] e_cnt);
    vec_t t;
    t.res = res; t.fl = fl; t.rd = rd; t.ctl = ctl; t.ew = ew;
    t.e_addr = e_addr; t.e_data = e_data; t.e_fv = e_fv;
    t.e_flags = e_flags; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] res, input logic [2:0] fl,
                       input logic [3:0] rd, input logic wer, input logic wef,
                       input logic fls, input logic stl);
    @(posedge clk);
    #1;
    in_valid = v; in_result = res; in_flags = fl; in_rd = rd;
    in_we_reg = wer; in_we_flags = wef; flush = fls; wb_stall = stl;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_rd = '0;
    in_we_reg = 1'b0; in_we_flags = 1'b0; flush = 1'b0; wb_stall = 1'b0;

    // streaming
    vq.push_back(mk(16'h0011, 3'b000, 4'd1,  4'b1100, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b000, 16'd0));
    vq.push_back(mk(16'h0022, 3'b000, 4'd2,  4'b1100, 2'b11, 4'd1,  16'h0011, 1'b1, 3'b000, 16'd0));
    vq.push_back(mk(16'h0033, 3'b000, 4'd3,  4'b1100, 2'b11, 4'd2,  16'h0022, 1'b1, 3'b000, 16'd1));
    vq.push_back(mk(16'h0044, 3'b000, 4'd4,  4'b1100, 2'b11, 4'd3,  16'h0033, 1'b1, 3'b000, 16'd2));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b11, 4'd4,  16'h0044, 1'b1, 3'b000, 16'd3));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b000, 16'd4));
    // backpressure
    vq.push_back(mk(16'h0800, 3'b000, 4'd8,  4'b1101, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b000, 16'd4));
    vq.push_back(mk(16'h0900, 3'b000, 4'd9,  4'b1101, 2'b10, 4'd8,  16'h0800, 1'b1, 3'b000, 16'd4));
    vq.push_back(mk(16'h0A00, 3'b000, 4'd10, 4'b1101, 2'b00, 4'd8,  16'h0800, 1'b1, 3'b000, 16'd4));
    vq.push_back(mk(16'h0A00, 3'b000, 4'd10, 4'b1100, 2'b01, 4'd8,  16'h0800, 1'b1, 3'b000, 16'd4));
    vq.push_back(mk(16'h0A00, 3'b000, 4'd10, 4'b1100, 2'b11, 4'd9,  16'h0900, 1'b1, 3'b000, 16'd5));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b11, 4'd10, 16'h0A00, 1'b1, 3'b000, 16'd6));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b000, 16'd7));
    // flags
    vq.push_back(mk(16'h0100, 3'b010, 4'd6,  4'b1110, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b000, 16'd7));
    vq.push_back(mk(16'h0200, 3'b101, 4'd7,  4'b1100, 2'b11, 4'd6,  16'h0100, 1'b1, 3'b000, 16'd7));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b11, 4'd7,  16'h0200, 1'b1, 3'b010, 16'd8));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b010, 16'd9));
    // r0 and forwarding under stall
    vq.push_back(mk(16'hBEEF, 3'b000, 4'd0,  4'b1100, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b010, 16'd9));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b10, 4'd0,  16'hBEEF, 1'b0, 3'b010, 16'd9));
    vq.push_back(mk(16'h0555, 3'b000, 4'd5,  4'b1101, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b010, 16'd10));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0001, 2'b10, 4'd5,  16'h0555, 1'b1, 3'b010, 16'd10));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0001, 2'b10, 4'd5,  16'h0555, 1'b1, 3'b010, 16'd10));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b11, 4'd5,  16'h0555, 1'b1, 3'b010, 16'd10));
    vq.push_back(mk(16'h0000, 3'b000, 4'd0,  4'b0000, 2'b10, 4'd0,  16'h0000, 1'b0, 3'b010, 16'd11));

    // reset
    do_reset();
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_flags", flags_q, 0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_fwd", fwd_valid, 0);
    $display("reset: ready=%b flags=%b cnt=%0d wr_en=%b", in_ready, flags_q, retired_cnt, rf_wr_en);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t t;
      t = vq[i];
      drive(t.ctl[3], t.res, t.fl, t.rd, t.ctl[2], t.ctl[1], 1'b0, t.ctl[0]);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), in_ready, t.ew[1]);
      chk($sformatf("v%0d_wr_en", i), rf_wr_en, t.ew[0]);
      chk($sformatf("v%0d_wr_addr", i), rf_wr_addr, t.e_addr);
      chk($sformatf("v%0d_wr_data", i), rf_wr_data, t.e_data);
      chk($sformatf("v%0d_fwd_valid", i), fwd_valid, t.e_fv);
      if (t.e_fv) begin
        chk($sformatf("v%0d_fwd_addr", i), fwd_addr, t.e_addr);
        chk($sformatf("v%0d_fwd_data", i), fwd_data, t.e_data);
      end
      chk($sformatf("v%0d_flags", i), flags_q, t.e_flags);
      chk($sformatf("v%0d_cnt", i), retired_cnt, t.e_cnt);
      $display("vec %0d: ready=%b wr_en=%b addr=%0d data=%h fwd=%b flags=%b cnt=%0d",
               i, in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_valid, flags_q, retired_cnt);
    end

    // flush with both entries full and a new op offered
    drive(1'b1, 16'h0B00, 3'b111, 4'd11, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 16'h0C00, 3'b000, 4'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_head_fwd_addr", fwd_addr, 11);
    drive(1'b1, 16'h0D00, 3'b000, 4'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_full_ready", in_ready, 0);
    drive(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_ready", in_ready, 1);
    chk("fl_wr_en", rf_wr_en, 0);
    chk("fl_fwd", fwd_valid, 0);
    chk("fl_flags", flags_q, 3'b010);
    chk("fl_cnt", retired_cnt, 11);
    drive(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_wr_en2", rf_wr_en, 0);
    chk("fl_cnt2", retired_cnt, 11);
    $display("flush: ready=%b wr_en=%b flags=%b cnt=%0d", in_ready, rf_wr_en, flags_q, retired_cnt);

    // counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 16'h1234, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_max", retired_cnt, 16'hFFFF);
    $display("wrap: cnt=%h", retired_cnt);
    drive(1'b1, 16'h4321, 3'b110, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_zero", retired_cnt, 0);
    chk("wrap_flags", flags_q, 3'b110);
    $display("wrap: cnt=%h flags=%b", retired_cnt, flags_q);

    // reset concurrent with flush and an offered op, buffer full
    drive(1'b1, 16'h0E00, 3'b000, 4'd14, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h0F00, 3'b000, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h0A0A, 3'b011, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rf_ready", in_ready, 1);
    chk("rf_fwd", fwd_valid, 0);
    chk("rf_wr_en", rf_wr_en, 0);
    chk("rf_flags", flags_q, 0);
    chk("rf_cnt", retired_cnt, 0);
    $display("reset+flush: ready=%b fwd=%b flags=%b cnt=%0d", in_ready, fwd_valid, flags_q, retired_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
